cpu16_io_wr: RTL and testbench

- Write-direction companion to the 6502 bus controller's illegal-opcode IO-read path.
- Detects the custom IO-write opcode 8'h8F fetched from the PCB bus.
- Substitutes a legal STA zp so the CPU drives its accumulator onto the bus, then captures that byte and issues a one-tick IO write strobe to the PCB.
- Sits between the CPU core and the PCB bus. The parent ORs its substitution output into the CPU data-in mux.

---
 rtl/cpu16_pkg.sv | 36 +++
 rtl/cpu16_io_wr.sv | 165 ++++++++++++++++
 tb/tb_cpu16_io_wr.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu16_pkg.sv
// Shared decode table and state types for the 6502 bus controller's
// illegal-opcode IO paths (read path 8'h67/8'h4B, write path 8'h8F).
package cpu16_pkg;

    // Custom IO opcodes fetched from the PCB bus
    localparam logic [7:0] OPC_IORD_A = 8'h67;
    localparam logic [7:0] OPC_IORD_B = 8'h4B;
    localparam logic [7:0] OPC_IOWR   = 8'h8F;

    // Legal opcode substituted so the CPU drives its accumulator onto the bus
    localparam logic [7:0] OPC_STA_ZP = 8'h85;

    typedef enum logic [1:0] {
        OPC_CLS_NONE = 2'd0,
        OPC_CLS_IORD = 2'd1,
        OPC_CLS_IOWR = 2'd2
    } opc_cls_e;

    typedef enum logic [1:0] {
        IOWR_IDLE    = 2'd0,
        IOWR_OPER    = 2'd1,
        IOWR_WAIT_WR = 2'd2
    } iowr_state_e;

    // One decode table for both IO directions; everything else is a normal opcode
    function automatic opc_cls_e decode_opc(input logic [7:0] opc);
        opc_cls_e cls;
        case (opc)
            OPC_IORD_A, OPC_IORD_B: cls = OPC_CLS_IORD;
            OPC_IOWR:               cls = OPC_CLS_IOWR;
            default:                cls = OPC_CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/cpu16_io_wr.sv
// IO-write path: on opcode 8'h8F the CPU is fed STA zp,SCRATCH_ZP instead,
// the accumulator byte it then writes is captured and forwarded to the PCB
// as a one-cen-period io_wr strobe. Internal RAM is blocked while waiting
// for that write so the scratch location is never actually clobbered.
module cpu16_io_wr #(
    parameter int         NUM_PORTS  = 4,
    parameter int         PORT_W     = 2,
    parameter logic [7:0] SCRATCH_ZP = 8'hFF,
    parameter int         TIMEOUT    = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cen,
    input  logic              SYNC,
    input  logic              RW,
    input  logic [15:0]       ABI,
    input  logic [7:0]        CPU_DBI,
    input  logic [7:0]        DBI,
    output logic              sub_en,
    output logic [7:0]        sub_dat,
    output logic              ram_blk,
    output logic              io_wr,
    output logic [PORT_W-1:0] io_port,
    output logic [7:0]        io_dat,
    output logic              err,
    output logic              busy
);
    import cpu16_pkg::*;

    localparam int               CNT_W       = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [15:0]      HIT_ADDR    = {8'h00, SCRATCH_ZP};
    localparam logic [7:0]       NUM_PORTS_B = 8'(NUM_PORTS);

    iowr_state_e       state_r, state_s;
    logic              sub_en_r, sub_en_s;
    logic [7:0]        sub_dat_r, sub_dat_s;
    logic              ram_blk_r, ram_blk_s;
    logic              io_wr_r, io_wr_s;
    logic [PORT_W-1:0] io_port_r, io_port_s;
    logic [7:0]        io_dat_r, io_dat_s;
    logic              err_r, err_s;
    logic              busy_r, busy_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [PORT_W-1:0] port_q_r, port_q_s;
    logic              valid_q_r, valid_q_s;
    logic              wr_hit_s;

    // Next-state and next-output decode; io_wr/err default low so they pulse for one tick
    always_comb begin
        state_s   = state_r;
        sub_en_s  = sub_en_r;
        sub_dat_s = sub_dat_r;
        ram_blk_s = ram_blk_r;
        io_wr_s   = 1'b0;
        io_port_s = io_port_r;
        io_dat_s  = io_dat_r;
        err_s     = 1'b0;
        cnt_s     = cnt_r;
        port_q_s  = port_q_r;
        valid_q_s = valid_q_r;
        wr_hit_s  = (RW == 1'b0) && (ABI == HIT_ADDR);

        case (state_r)
            IOWR_IDLE: begin
                if (SYNC && (decode_opc(DBI) == OPC_CLS_IOWR)) begin
                    sub_en_s  = 1'b1;
                    sub_dat_s = OPC_STA_ZP;
                    state_s   = IOWR_OPER;
                end else begin
                    sub_en_s  = 1'b0;
                end
            end
            IOWR_OPER: begin
                if (SYNC) begin
                    // A new fetch here means the CPU never took the substituted STA
                    sub_en_s = 1'b0;
                    err_s    = 1'b1;
                    state_s  = IOWR_IDLE;
                end else begin
                    port_q_s  = DBI[PORT_W-1:0];
                    valid_q_s = (DBI < NUM_PORTS_B);
                    sub_en_s  = 1'b1;
                    sub_dat_s = SCRATCH_ZP;
                    cnt_s     = {CNT_W{1'b0}};
                    ram_blk_s = 1'b1;
                    state_s   = IOWR_WAIT_WR;
                end
            end
            IOWR_WAIT_WR: begin
                sub_en_s = 1'b0;
                if (wr_hit_s) begin
                    if (valid_q_r) begin
                        io_wr_s   = 1'b1;
                        io_port_s = port_q_r;
                        io_dat_s  = CPU_DBI;
                    end else begin
                        err_s     = 1'b1;
                    end
                    ram_blk_s = 1'b0;
                    state_s   = IOWR_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        // Timeout wins over any opcode fetched on this same tick
                        err_s     = 1'b1;
                        ram_blk_s = 1'b0;
                        state_s   = IOWR_IDLE;
                    end else begin
                        ram_blk_s = 1'b1;
                    end
                end
            end
            default: begin
                sub_en_s  = 1'b0;
                ram_blk_s = 1'b0;
                state_s   = IOWR_IDLE;
            end
        endcase

        busy_s = (state_s != IOWR_IDLE);
    end

    // State and output registers; everything advances only on cen ticks
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= IOWR_IDLE;
            sub_en_r  <= 1'b0;
            sub_dat_r <= 8'h00;
            ram_blk_r <= 1'b0;
            io_wr_r   <= 1'b0;
            io_port_r <= {PORT_W{1'b0}};
            io_dat_r  <= 8'h00;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            port_q_r  <= {PORT_W{1'b0}};
            valid_q_r <= 1'b0;
        end else if (cen) begin
            state_r   <= state_s;
            sub_en_r  <= sub_en_s;
            sub_dat_r <= sub_dat_s;
            ram_blk_r <= ram_blk_s;
            io_wr_r   <= io_wr_s;
            io_port_r <= io_port_s;
            io_dat_r  <= io_dat_s;
            err_r     <= err_s;
            busy_r    <= busy_s;
            cnt_r     <= cnt_s;
            port_q_r  <= port_q_s;
            valid_q_r <= valid_q_s;
        end
    end

    assign sub_en  = sub_en_r;
    assign sub_dat = sub_dat_r;
    assign ram_blk = ram_blk_r;
    assign io_wr   = io_wr_r;
    assign io_port = io_port_r;
    assign io_dat  = io_dat_r;
    assign err     = err_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_cpu16_io_wr.sv
// Directed bench for cpu16_io_wr. A transaction-level model turns each
// IO-write request into the expected per-tick output trace; one compare
// process checks every DUT output against it on every clock.
module tb_cpu16_io_wr;

    localparam int         NUM_PORTS = 4;
    localparam int         PORT_W    = 2;
    localparam logic [7:0] SCRATCH   = 8'hFF;
    localparam int         TIMEOUT   = 2;

    logic        clk = 1'b0;
    logic        reset_n, cen, SYNC, RW;
    logic [15:0] ABI;
    logic [7:0]  CPU_DBI, DBI;
    logic        sub_en, ram_blk, io_wr, err, busy;
    logic [7:0]  sub_dat, io_dat;
    logic [PORT_W-1:0] io_port;

    cpu16_io_wr #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W),
        .SCRATCH_ZP(SCRATCH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cen(cen), .SYNC(SYNC), .RW(RW),
        .ABI(ABI), .CPU_DBI(CPU_DBI), .DBI(DBI),
        .sub_en(sub_en), .sub_dat(sub_dat), .ram_blk(ram_blk),
        .io_wr(io_wr), .io_port(io_port), .io_dat(io_dat),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected outputs (updated by the model just after each active edge)
    logic        e_sub_en, e_ram_blk, e_io_wr, e_err, e_busy;
    logic [7:0]  e_sub_dat, e_io_dat;
    logic [PORT_W-1:0] e_io_port;
    // Model memory: last substituted byte and last delivered IO write
    logic [7:0]  m_sub_dat, m_dat;
    logic [PORT_W-1:0] m_port;

    logic chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cen_div = 1;
    int   wr_clks = 0;
    int   wr_pulses = 0;
    logic io_wr_d = 1'b0;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every output against the model, on every clock
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("sub_en",  {15'd0, sub_en},  {15'd0, e_sub_en});
            cmp("sub_dat", {8'd0, sub_dat},  {8'd0, e_sub_dat});
            cmp("ram_blk", {15'd0, ram_blk}, {15'd0, e_ram_blk});
            cmp("io_wr",   {15'd0, io_wr},   {15'd0, e_io_wr});
            cmp("io_port", {14'd0, io_port}, {14'd0, e_io_port});
            cmp("io_dat",  {8'd0, io_dat},   {8'd0, e_io_dat});
            cmp("err",     {15'd0, err},     {15'd0, e_err});
            cmp("busy",    {15'd0, busy},    {15'd0, e_busy});
        end
    end

    // Strobe width / count monitor
    always @(negedge clk) begin
        if (io_wr === 1'b1) wr_clks++;
        if (io_wr === 1'b1 && io_wr_d !== 1'b1) wr_pulses++;
        io_wr_d <= io_wr;
    end

    task automatic expect_out(input logic sen, input logic rb, input logic iw,
                              input logic er, input logic bz);
        e_sub_en  = sen;
        e_ram_blk = rb;
        e_io_wr   = iw;
        e_err     = er;
        e_busy    = bz;
        e_sub_dat = m_sub_dat;
        e_io_port = m_port;
        e_io_dat  = m_dat;
    endtask

    // One CPU tick: inputs held for cen_div clocks, cen high on the last one
    task automatic cen_tick(input logic sync, input logic rw, input logic [15:0] abi,
                            input logic [7:0] cdbi, input logic [7:0] dbi);
        SYNC = sync; RW = rw; ABI = abi; CPU_DBI = cdbi; DBI = dbi;
        for (int i = 1; i < cen_div; i++) begin
            cen = 1'b0;
            @(posedge clk); #1;
        end
        cen = 1'b1;
        @(posedge clk); #1;
        cen = 1'b0;
    endtask

    task automatic idle_tick();
        cen_tick(1'b0, 1'b1, 16'h2000, 8'h00, 8'hEA);
        expect_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Model of one IO-write request: opcode, operand, then the write cycle
    // appears wr_at ticks into the wait (wr_at >= TIMEOUT means never).
    task automatic io_write(input logic [7:0] oper, input logic [7:0] data,
                            input int wr_at, input logic sync_at_to);
        logic ok;
        logic done;
        ok   = (oper < NUM_PORTS);
        done = 1'b0;
        cen_tick(1'b1, 1'b1, 16'h1000, 8'h00, 8'h8F);
        m_sub_dat = 8'h85;
        expect_out(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cen_tick(1'b0, 1'b1, 16'h1001, 8'h00, oper);
        m_sub_dat = SCRATCH;
        expect_out(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < TIMEOUT; j++) begin
            if (!done) begin
                if (j == wr_at) begin
                    cen_tick(1'b0, 1'b0, {8'h00, SCRATCH}, data, 8'h00);
                    if (ok) begin
                        m_port = oper[PORT_W-1:0];
                        m_dat  = data;
                    end
                    expect_out(1'b0, 1'b0, ok, !ok, 1'b0);
                    done = 1'b1;
                end else if (j == TIMEOUT - 1) begin
                    cen_tick(sync_at_to, 1'b1, 16'h0200, 8'h00, sync_at_to ? 8'h8F : 8'hEA);
                    expect_out(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                    done = 1'b1;
                end else begin
                    cen_tick(1'b0, 1'b1, 16'h0200, 8'h00, 8'hEA);
                    expect_out(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset_n = 1'b0; cen = 1'b0; SYNC = 1'b0; RW = 1'b1;
        ABI = 16'h0000; CPU_DBI = 8'h00; DBI = 8'h00;
        m_sub_dat = 8'h00; m_port = '0; m_dat = 8'h00;
        expect_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_en = 1'b1;
        cen = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        cen = 1'b0;
        cmp("rst_sub_dat", {8'd0, sub_dat}, 16'h0000);
        cmp("rst_busy", {15'd0, busy}, 16'h0000);

        // Nominal write to port 2
        io_write(8'h02, 8'h5A, 0, 1'b0);
        cmp("nom_io_wr", {15'd0, io_wr}, 16'h0001);
        cmp("nom_io_port", {14'd0, io_port}, 16'h0002);
        cmp("nom_io_dat", {8'd0, io_dat}, 16'h005A);
        cmp("nom_sub_dat", {8'd0, sub_dat}, 16'h00FF);
        idle_tick();
        cmp("nom_io_wr_clr", {15'd0, io_wr}, 16'h0000);

        // Rejected ports: 7, boundary 4, and 8'h82 (low bits valid, full byte not)
        io_write(8'h07, 8'h33, 0, 1'b0);
        cmp("bad_err", {15'd0, err}, 16'h0001);
        cmp("bad_io_port_kept", {14'd0, io_port}, 16'h0002);
        idle_tick();
        io_write(8'h04, 8'h34, 0, 1'b0);
        idle_tick();
        io_write(8'h82, 8'h35, 0, 1'b0);
        idle_tick();

        // Highest valid port, write arriving on the last allowed wait tick
        io_write(8'h03, 8'hC3, TIMEOUT - 1, 1'b0);
        cmp("late_io_dat", {8'd0, io_dat}, 16'h00C3);
        idle_tick();

        // Timeout, then timeout coinciding with a fresh 8F fetch (not re-armed)
        io_write(8'h01, 8'h44, TIMEOUT, 1'b0);
        cmp("to_err", {15'd0, err}, 16'h0001);
        cmp("to_ram_blk", {15'd0, ram_blk}, 16'h0000);
        idle_tick();
        io_write(8'h01, 8'h45, TIMEOUT, 1'b1);
        idle_tick();
        cmp("to_not_rearmed", {15'd0, busy}, 16'h0000);

        // SYNC during the operand tick
        cen_tick(1'b1, 1'b1, 16'h1000, 8'h00, 8'h8F);
        m_sub_dat = 8'h85;
        expect_out(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cen_tick(1'b1, 1'b1, 16'h1001, 8'h00, 8'hEA);
        expect_out(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_tick();

        // Opcodes owned by other paths
        cen_tick(1'b1, 1'b1, 16'h3000, 8'h00, 8'h67);
        expect_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cen_tick(1'b1, 1'b1, 16'h3001, 8'h00, 8'h4B);
        expect_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cen_tick(1'b1, 1'b1, 16'h3002, 8'h00, 8'h0F);
        expect_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // 8F without SYNC is just data
        cen_tick(1'b0, 1'b1, 16'h3003, 8'h00, 8'h8F);
        expect_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset while waiting for the write cycle, with cen low
        cen_tick(1'b1, 1'b1, 16'h1000, 8'h00, 8'h8F);
        m_sub_dat = 8'h85;
        expect_out(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cen_tick(1'b0, 1'b1, 16'h1001, 8'h00, 8'h01);
        m_sub_dat = SCRATCH;
        expect_out(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        reset_n = 1'b0;
        cen = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_sub_dat = 8'h00; m_port = '0; m_dat = 8'h00;
        expect_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cen_tick(1'b0, 1'b0, {8'h00, SCRATCH}, 8'h77, 8'h00);
        expect_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp("rst_mid_io_wr", {15'd0, io_wr}, 16'h0000);
        cmp("rst_mid_io_dat", {8'd0, io_dat}, 16'h0000);
        idle_tick();

        // cen every 4th clock, back-to-back writes
        cen_div = 4;
        wr_clks = 0;
        wr_pulses = 0;
        io_write(8'h00, 8'h11, 0, 1'b0);
        cmp("b2b_first_dat", {8'd0, io_dat}, 16'h0011);
        io_write(8'h03, 8'hEE, 0, 1'b0);
        cmp("b2b_second_port", {14'd0, io_port}, 16'h0003);
        cmp("b2b_second_dat", {8'd0, io_dat}, 16'h00EE);
        idle_tick();
        idle_tick();
        cmp("b2b_pulses", wr_pulses[15:0], 16'd2);
        cmp("b2b_wr_clks", wr_clks[15:0], 16'd8);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
